bridge_1xn: RTL

Parametrised 1-to-N data-side bridge between the CPU data port and N memory-mapped slaves (data RAM, CLINT, AXI controller, further peripherals). It decodes each request against per-slave base/mask windows and issues it to the selected slave using valid/ready handshakes. It routes the single outstanding response back to the CPU, which lets multi-cycle slaves stall the core. Unmapped addresses and unresponsive slaves return an error response instead of hanging the pipeline.

---
 rtl/bridge_pkg.sv | 20 ++
 rtl/bridge_addr_dec.sv | 33 +++
 rtl/bridge_1xn.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the 1-to-N data-side bridge.
// Latency: n/a (types only).
// Backpressure: n/a.
package bridge_pkg;

    // Transaction FSM: one request in flight at a time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Slave index width; wide enough for 8 slaves plus the "no slave" code.
    localparam int SEL_W = 4;

    // Select value reported when no window matches and there is no default slave.
    localparam logic [SEL_W-1:0] DEC_NONE = '1;

endpackage

// File: rtl/bridge_addr_dec.sv
// Priority address decoder: lowest-index matching base/mask window wins, else the default slave.
// Latency: purely combinational.
// Backpressure: none; ports are addr (low 32 bits) in, sel index and hit out.
module bridge_addr_dec
    import bridge_pkg::*;
#(
    parameter int                   N_SLV       = 3,
    parameter logic [N_SLV*32-1:0]  SLV_BASE    = {32'hA000_0000, 32'h0200_0000, 32'h8000_0000},
    parameter logic [N_SLV*32-1:0]  SLV_MASK    = {32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000},
    parameter int                   DEFAULT_SLV = N_SLV
) (
    input  logic [31:0]      addr,
    output logic [SEL_W-1:0] sel,
    output logic             hit
);

    always_comb begin
        sel = DEC_NONE;
        hit = 1'b0;
        // Walk from the top down so the lowest matching index is the last writer.
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                sel = SEL_W'(i);
                hit = 1'b1;
            end
        end
        if (!hit && (DEFAULT_SLV < N_SLV)) begin
            sel = SEL_W'(DEFAULT_SLV);
            hit = 1'b1;
        end
    end

endmodule

// File: rtl/bridge_1xn.sv
// 1-to-N CPU data-port bridge: decodes, forwards one request to a slave, returns one response.
// Latency: accept T -> s_req_valid T+1 -> m_resp_valid T+2 (zero-wait slave); decode error at T+1.
// Backpressure: m_req_ready only in IDLE; s_req_valid held until s_req_ready; timeout aborts.
// Ports: m_* CPU request/response, s_* one-hot slave requests with shared we/addr/wdata,
//        s_resp_valid/s_rdata per-slave responses.
module bridge_1xn
    import bridge_pkg::*;
#(
    parameter int                   N_SLV       = 3,
    parameter int                   ADDR_W      = 64,
    parameter int                   DATA_W      = 64,
    parameter logic [N_SLV*32-1:0]  SLV_BASE    = {32'hA000_0000, 32'h0200_0000, 32'h8000_0000},
    parameter logic [N_SLV*32-1:0]  SLV_MASK    = {32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000},
    parameter int                   DEFAULT_SLV = N_SLV,
    parameter int                   TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_req_valid,
    output logic                    m_req_ready,
    input  logic [DATA_W/8-1:0]     m_we,
    input  logic [ADDR_W-1:0]       m_addr,
    input  logic [DATA_W-1:0]       m_wdata,
    output logic                    m_resp_valid,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    m_resp_err,
    output logic [N_SLV-1:0]        s_req_valid,
    input  logic [N_SLV-1:0]        s_req_ready,
    output logic [DATA_W/8-1:0]     s_we,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [N_SLV-1:0]        s_resp_valid,
    input  logic [N_SLV*DATA_W-1:0] s_rdata
);

    // Counter is one bit wider than strictly needed so TIMEOUT_CYC = 0 still elaborates.
    localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 2);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [CNT_W-1:0]   cnt;

    logic [SEL_W-1:0]   dec_sel;
    logic               dec_hit;
    logic [N_SLV-1:0]   dec_onehot;

    logic               sel_ready;
    logic               sel_resp;
    logic [DATA_W-1:0]  sel_rdata;
    logic               timeout_hit;
    logic [DATA_W-1:0]  resp_data;

    bridge_addr_dec #(
        .N_SLV       (N_SLV),
        .SLV_BASE    (SLV_BASE),
        .SLV_MASK    (SLV_MASK),
        .DEFAULT_SLV (DEFAULT_SLV)
    ) u_dec (
        .addr (m_addr[31:0]),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    // Per-slave muxing keyed on the latched select; a DEC_NONE select picks nothing.
    always_comb begin
        dec_onehot = '0;
        sel_ready  = 1'b0;
        sel_resp   = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < N_SLV; i++) begin
            dec_onehot[i] = dec_hit && (dec_sel == SEL_W'(i));
            if (sel_q == SEL_W'(i)) begin
                sel_ready = s_req_ready[i];
                sel_resp  = s_resp_valid[i];
                sel_rdata = s_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);
    // Writes are acknowledged with zero data whatever the slave drives.
    assign resp_data   = (s_we != '0) ? '0 : sel_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sel_q        <= DEC_NONE;
            cnt          <= '0;
            m_req_ready  <= 1'b0;
            m_resp_valid <= 1'b0;
            m_rdata      <= '0;
            m_resp_err   <= 1'b0;
            s_req_valid  <= '0;
            s_we         <= '0;
            s_addr       <= '0;
            s_wdata      <= '0;
        end else begin
            m_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    m_req_ready <= 1'b1;
                    if (m_req_valid && m_req_ready) begin
                        m_req_ready <= 1'b0;
                        s_we        <= m_we;
                        s_addr      <= m_addr;
                        s_wdata     <= m_wdata;
                        sel_q       <= dec_sel;
                        cnt         <= '0;
                        if (dec_hit) begin
                            s_req_valid <= dec_onehot;
                            state       <= REQ;
                        end else begin
                            m_resp_err   <= 1'b1;
                            m_rdata      <= '0;
                            m_resp_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (sel_ready && sel_resp) begin
                        s_req_valid  <= '0;
                        m_rdata      <= resp_data;
                        m_resp_err   <= 1'b0;
                        m_resp_valid <= 1'b1;
                        state        <= DONE;
                    end else if (timeout_hit) begin
                        s_req_valid  <= '0;
                        m_rdata      <= '0;
                        m_resp_err   <= 1'b1;
                        m_resp_valid <= 1'b1;
                        state        <= DONE;
                    end else if (sel_ready) begin
                        s_req_valid <= '0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    cnt <= cnt + 1'b1;
                    if (sel_resp) begin
                        m_rdata      <= resp_data;
                        m_resp_err   <= 1'b0;
                        m_resp_valid <= 1'b1;
                        state        <= DONE;
                    end else if (timeout_hit) begin
                        m_rdata      <= '0;
                        m_resp_err   <= 1'b1;
                        m_resp_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    m_req_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
